// File: rtl/cpu_bus_mem_pkg.sv
// Shared types and constants for the cpu_bus_mem memory/I-O target.
package cpu_bus_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Default location of the optional board-pin output register.
  localparam logic [ADDR_W-1:0] MMIO_ADDR_DEFAULT = 8'hFF;

  // Core write sequence: address phase then data phase.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wstate_e;

  // True when an 8-bit bus address falls inside a DEPTH-byte array.
  function automatic logic addr_in_range(logic [ADDR_W-1:0] addr, int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/cpu_bus_mem_loader.sv
// Byte-stream loader: fills the array from address 0 while the core is held in
// reset. Produces a write port that the top level muxes into the array.
module cpu_bus_mem_loader
  import cpu_bus_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] load_ptr,
  output logic              load_full,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  // One extra bit so a 256-byte array can still count up to its depth.
  localparam logic [ADDR_W:0] PtrMax = DEPTH[ADDR_W:0];

  logic [ADDR_W:0] ptr_q, ptr_d;
  logic            full_q, full_d;
  logic            accept;

  assign accept = load_en & load_valid & ~full_q;

  // Next pointer/full: cleared whenever loading is off, advance per accepted byte.
  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    if (!load_en) begin
      ptr_d  = '0;
      full_d = 1'b0;
    end else if (accept) begin
      ptr_d  = ptr_q + 1'b1;
      full_d = (ptr_d == PtrMax);
    end
  end

  // Pointer and full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
    end
  end

  assign load_ptr  = ptr_q[ADDR_W-1:0];
  assign load_full = full_q;
  assign mem_we    = accept;
  assign mem_waddr = ptr_q[ADDR_W-1:0];
  assign mem_wdata = load_data;

endmodule

// File: rtl/cpu_bus_mem.sv
// Memory and I/O target on the CPU's 8-bit multiplexed bus.
// Combinational reads, two-phase core writes, and a reset-time byte loader.
// Optional output register enabled by defining CPU_BUS_MEM_MMIO_EN.
module cpu_bus_mem
  import cpu_bus_mem_pkg::*;
#(
  parameter int unsigned       DEPTH     = 32,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rd,
  input  logic              bus_wr,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] load_ptr,
  output logic              load_full
`ifdef CPU_BUS_MEM_MMIO_EN
  ,
  output logic [DATA_W-1:0] mmio_out
`endif
);

  // Keep the loaded region below the output register address.
  localparam int unsigned LoadDepth = (32'(MMIO_ADDR) < DEPTH) ? 32'(MMIO_ADDR) : DEPTH;

  logic [DATA_W-1:0] mem_q [DEPTH];

  wstate_e           state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              core_commit;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0] ld_wdata;

  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  cpu_bus_mem_loader #(
    .DEPTH (LoadDepth)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ptr   (load_ptr),
    .load_full  (load_full),
    .mem_we     (ld_we),
    .mem_waddr  (ld_waddr),
    .mem_wdata  (ld_wdata)
  );

  // Write FSM next state: latch address on the strobe, then take data next cycle.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    unique case (state_q)
      W_IDLE: begin
        if (bus_wr && !load_en) begin
          state_d = W_DATA;
          waddr_d = bus_addr;
        end
      end
      W_DATA:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
    // Loading owns the array; any half-finished core write is abandoned.
    if (load_en) begin
      state_d = W_IDLE;
    end
  end

  // Write FSM state and latched address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
    end
  end

  // Data phase: bus_addr carries the write data this cycle.
  assign core_commit = (state_q == W_DATA) && !load_en;

  // Array write port: loader when loading, otherwise an in-range core commit.
  always_comb begin
    we      = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (ld_we) begin
      we      = 1'b1;
      wr_addr = ld_waddr;
      wr_data = ld_wdata;
    end else if (core_commit && addr_in_range(waddr_q, DEPTH)) begin
      we      = 1'b1;
      wr_addr = waddr_q;
      wr_data = bus_addr;
    end
  end

  // Storage array, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_addr == 8'(i)) begin
          mem_q[i] <= wr_data;
        end
      end
    end
  end

`ifdef CPU_BUS_MEM_MMIO_EN
  logic [DATA_W-1:0] mmio_q;

  // Output register updated by a completed core write to its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_q <= '0;
    end else if (core_commit && (waddr_q == MMIO_ADDR)) begin
      mmio_q <= bus_addr;
    end
  end

  assign mmio_out = mmio_q;
`endif

  // Zero-latency read mux; unmapped addresses and idle strobe read as zero.
  always_comb begin
    bus_rdata = '0;
    if (bus_rd) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (bus_addr == 8'(i)) begin
          bus_rdata = mem_q[i];
        end
      end
`ifdef CPU_BUS_MEM_MMIO_EN
      if (bus_addr == MMIO_ADDR) begin
        bus_rdata = mmio_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Self-checking bench for cpu_bus_mem: directed literal checks plus random
// traffic compared every cycle against a transaction-level model.
module tb_cpu_bus_mem;

  localparam int unsigned DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_rd = 1'b0;
  logic       bus_wr = 1'b0;
  logic [7:0] bus_rdata;
  logic       load_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] load_ptr;
  logic       load_full;
`ifdef CPU_BUS_MEM_MMIO_EN
  logic [7:0] mmio_out;
`endif

  cpu_bus_mem #(
    .DEPTH     (DEPTH),
    .MMIO_ADDR (8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_rd     (bus_rd),
    .bus_wr     (bus_wr),
    .bus_rdata  (bus_rdata),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ptr   (load_ptr),
    .load_full  (load_full)
`ifdef CPU_BUS_MEM_MMIO_EN
    ,
    .mmio_out   (mmio_out)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  // Reference model: byte array, pending core write, loader pointer.
  logic [7:0] m_mem [256];
  int         m_ptr;
  bit         m_full;
  bit         m_pend;
  logic [7:0] m_paddr;
  logic [7:0] m_mmio;
`ifdef CPU_BUS_MEM_MMIO_EN
  localparam bit MmioOn = 1'b1;
`else
  localparam bit MmioOn = 1'b0;
`endif

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_ptr = 0; m_full = 0; m_pend = 0; m_paddr = 8'h00; m_mmio = 8'h00;
  endtask

  // Effect of one rising edge given the inputs currently on the pins.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (load_en) begin
      m_pend = 0;
      if (load_valid && !m_full) begin
        m_mem[m_ptr] = load_data;
        m_ptr++;
        if (m_ptr == DEPTH) m_full = 1;
      end
    end else begin
      m_ptr = 0;
      m_full = 0;
      if (m_pend) begin
        if (int'(m_paddr) < DEPTH) m_mem[m_paddr] = bus_addr;
        if (MmioOn && m_paddr == 8'hFF) m_mmio = bus_addr;
        m_pend = 0;
      end else if (bus_wr) begin
        m_pend = 1;
        m_paddr = bus_addr;
      end
    end
  endtask

  function automatic logic [7:0] exp_rdata();
    if (!bus_rd) return 8'h00;
    if (int'(bus_addr) < DEPTH) return m_mem[bus_addr];
    if (MmioOn && bus_addr == 8'hFF) return m_mmio;
    return 8'h00;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (run) begin
      chk("rdata", bus_rdata, exp_rdata());
      chk("load_ptr", load_ptr, 8'(m_ptr));
      chk("load_full", {7'b0, load_full}, {7'b0, m_full});
`ifdef CPU_BUS_MEM_MMIO_EN
      chk("mmio_out", mmio_out, m_mmio);
`endif
    end
  end

  task automatic drive(bit rd, bit wr, logic [7:0] a, bit le, bit lv, logic [7:0] ld);
    bus_rd = rd; bus_wr = wr; bus_addr = a;
    load_en = le; load_valid = lv; load_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(bit rd, bit wr, logic [7:0] a, bit le, bit lv, logic [7:0] ld);
    drive(rd, wr, a, le, lv, ld);
    tick();
  endtask

  initial begin
    bit         le;
    int         r;
    logic [7:0] a;

    model_reset();
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    run = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state.
    drive(1, 0, 8'h05, 0, 0, 8'h00);
    @(negedge clk);
    chk("rst_read5", bus_rdata, 8'h00);
    chk("rst_ptr", load_ptr, 8'h00);
    chk("rst_full", {7'b0, load_full}, 8'h00);
    tick();

    // Short load stream.
    cyc(0, 0, 8'h00, 1, 1, 8'h11);
    cyc(0, 0, 8'h00, 1, 1, 8'h22);
    cyc(0, 0, 8'h00, 1, 1, 8'h33);
    drive(1, 0, 8'h01, 1, 0, 8'h00);
    @(negedge clk);
    chk("load_ptr3", load_ptr, 8'h03);
    chk("load_rd1", bus_rdata, 8'h22);
    tick();

    // Overfill: DEPTH+2 bytes, last two dropped.
    cyc(0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(0, 0, 8'h00, 1, 1, 8'(8'h80 + i));
      if (i == DEPTH - 2) begin
        @(negedge clk);
        chk("full_early", {7'b0, load_full}, 8'h00);
      end
      if (i == DEPTH - 1) begin
        @(negedge clk);
        chk("full_set", {7'b0, load_full}, 8'h01);
        chk("ptr_full", load_ptr, 8'h20);
      end
    end
    drive(1, 0, 8'h00, 0, 0, 8'h00);
    @(negedge clk);
    chk("mem0_kept", bus_rdata, 8'h80);
    tick();
    drive(1, 0, 8'h1F, 0, 0, 8'h00);
    @(negedge clk);
    chk("mem_last", bus_rdata, 8'h9F);
    tick();

    // Core write, then a write whose data phase reads the same address.
    cyc(0, 1, 8'h04, 0, 0, 8'h00);
    cyc(0, 0, 8'hA5, 0, 0, 8'h00);
    drive(1, 0, 8'h04, 0, 0, 8'h00);
    @(negedge clk);
    chk("wr_a5", bus_rdata, 8'hA5);
    tick();
    cyc(0, 1, 8'h04, 0, 0, 8'h00);
    drive(1, 0, 8'h04, 0, 0, 8'h00);
    @(negedge clk);
    chk("dphase_old", bus_rdata, 8'hA5);
    tick();
    drive(1, 0, 8'h04, 0, 0, 8'h00);
    @(negedge clk);
    chk("wr_04", bus_rdata, 8'h04);
    tick();

    // Out-of-range write dropped.
    cyc(0, 1, 8'h40, 0, 0, 8'h00);
    cyc(0, 0, 8'h77, 0, 0, 8'h00);
    drive(1, 0, 8'h40, 0, 0, 8'h00);
    @(negedge clk);
    chk("oor_read", bus_rdata, 8'h00);
    tick();

    // Output register (reads 0x00 when not built in).
    cyc(0, 1, 8'hFF, 0, 0, 8'h00);
    cyc(0, 0, 8'h3C, 0, 0, 8'h00);
    drive(1, 0, 8'hFF, 0, 0, 8'h00);
    @(negedge clk);
    chk("mmio_read", bus_rdata, MmioOn ? 8'h3C : 8'h00);
`ifdef CPU_BUS_MEM_MMIO_EN
    chk("mmio_pins", mmio_out, 8'h3C);
`endif
    tick();
    cyc(0, 1, 8'hFF, 0, 0, 8'h00);
    cyc(0, 0, 8'h55, 1, 0, 8'h00);
    drive(1, 0, 8'hFF, 0, 0, 8'h00);
    @(negedge clk);
    chk("mmio_discard", bus_rdata, MmioOn ? 8'h3C : 8'h00);
    tick();

    // load_en during a data phase discards the array write too.
    cyc(0, 1, 8'h02, 0, 0, 8'h00);
    cyc(0, 0, 8'hEE, 1, 0, 8'h00);
    drive(1, 0, 8'h02, 0, 0, 8'h00);
    @(negedge clk);
    chk("load_abort", bus_rdata, 8'h82);
    tick();

    // Reset in the middle of a pending write.
    cyc(0, 1, 8'h03, 0, 0, 8'h00);
    drive(0, 0, 8'h99, 0, 0, 8'h00);
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(1, 0, 8'h03, 0, 0, 8'h00);
    @(negedge clk);
    chk("rst_mid", bus_rdata, 8'h00);
    tick();

    // Random traffic against the model.
    le = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) le = ~le;
      r = $urandom_range(0, 9);
      if (r < 7) a = 8'($urandom_range(0, DEPTH - 1));
      else if (r == 7) a = 8'hFF;
      else a = 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, le,
            1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      tick();
      rst_n = 1'b1;
    end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
